// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: central hazard / stall controller for the five pipeline
// registers (pc, if_id, id_ex, ex_mem, mem_wb). It resolves data-bus waits,
// EX redirects, load-use hazards and instruction-bus waits into 2-bit stall
// codes (NEXT / KEEP / ZERO). It also tracks a fetch that must be discarded
// after a redirect, and it flags data accesses that stay stuck too long.
//
// Optional build macro: STALL_PERF_CNT_EN adds three wrapping performance
// counters (load-use, redirect/flush and mem-wait cycles) together with their
// CNT_W parameter. Without the macro the counters, their ports and CNT_W are
// absent, and every other behaviour is unchanged.
module pipe_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
`ifdef STALL_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_rs1_ren,
  input  logic       id_rs2_ren,
  input  logic       ex_mem_rena,
  input  logic       ex_rd_wena,
  input  logic [4:0] ex_rd_waddr,
  input  logic       ex_redirect,
  input  logic       if_req,
  input  logic       if_ready,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic [1:0] pc_stall,
  output logic [1:0] if_id_stall,
  output logic [1:0] id_ex_stall,
  output logic [1:0] ex_mem_stall,
  output logic [1:0] mem_wb_stall,
  output logic       mem_timeout,
  output logic       flush_pend
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_load_use,
  output logic [CNT_W-1:0] cnt_flush,
  output logic [CNT_W-1:0] cnt_mem_wait
`endif
);

  // Stall codes understood by every pipeline register.
  localparam logic [1:0] SC_NEXT = 2'b00;
  localparam logic [1:0] SC_KEEP = 2'b01;
  localparam logic [1:0] SC_ZERO = 2'b10;

  // Fetch-discard FSM states.
  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  // Last counter value before the stuck-access pulse fires.
  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 32'd1);

  // Hazard terms.
  logic mem_busy_s;
  logic if_busy_s;
  logic rd_valid_s;
  logic rs1_hit_s;
  logic rs2_hit_s;
  logic load_use_s;

  // One-hot winner of the priority ladder (at most one set).
  logic rule_mem_s;
  logic rule_redir_s;
  logic rule_lu_s;
  logic rule_flush_s;
  logic rule_if_s;

  // Combined stall vector {pc, if_id, id_ex, ex_mem, mem_wb}.
  logic [9:0] stall_vec_s;

  // State.
  logic [0:0]  state_q;
  logic [0:0]  state_d;
  logic [15:0] wait_cnt_q;
  logic [15:0] wait_cnt_d;
  logic        timeout_q;
  logic        timeout_d;

  assign mem_busy_s = mem_req & ~mem_ready;
  assign if_busy_s  = if_req & ~if_ready;

  // x0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign rd_valid_s = ex_mem_rena & ex_rd_wena & (ex_rd_waddr != 5'd0);
  assign rs1_hit_s  = id_rs1_ren & (id_rs1_addr == ex_rd_waddr);
  assign rs2_hit_s  = id_rs2_ren & (id_rs2_addr == ex_rd_waddr);
  assign load_use_s = rd_valid_s & (rs1_hit_s | rs2_hit_s);

  // Priority ladder: each rule only wins when every higher rule is idle.
  // A redirect under mem_busy is not lost: EX is held and re-presents it.
  assign rule_mem_s   = mem_busy_s;
  assign rule_redir_s = ~mem_busy_s & ex_redirect;
  assign rule_lu_s    = ~mem_busy_s & ~ex_redirect & load_use_s;
  assign rule_flush_s = ~mem_busy_s & ~ex_redirect & ~load_use_s & (state_q == S_FLUSH);
  assign rule_if_s    = ~mem_busy_s & ~ex_redirect & ~load_use_s & (state_q == S_RUN) & if_busy_s;

  // Stall code selection; reset forces the safe pattern with the PC held.
  always_comb begin
    stall_vec_s = {SC_NEXT, SC_NEXT, SC_NEXT, SC_NEXT, SC_NEXT};
    if (!rst_n) begin
      stall_vec_s = {SC_KEEP, SC_ZERO, SC_ZERO, SC_ZERO, SC_ZERO};
    end else if (rule_mem_s) begin
      stall_vec_s = {SC_KEEP, SC_KEEP, SC_KEEP, SC_KEEP, SC_ZERO};
    end else if (rule_redir_s) begin
      stall_vec_s = {SC_NEXT, SC_ZERO, SC_ZERO, SC_NEXT, SC_NEXT};
    end else if (rule_lu_s) begin
      stall_vec_s = {SC_KEEP, SC_KEEP, SC_ZERO, SC_NEXT, SC_NEXT};
    end else if (rule_flush_s) begin
      // The in-flight fetch belongs to the wrong path: drop whatever arrives.
      stall_vec_s = {SC_KEEP, SC_ZERO, SC_NEXT, SC_NEXT, SC_NEXT};
    end else if (rule_if_s) begin
      stall_vec_s = {SC_KEEP, SC_ZERO, SC_NEXT, SC_NEXT, SC_NEXT};
    end else begin
      stall_vec_s = {SC_NEXT, SC_NEXT, SC_NEXT, SC_NEXT, SC_NEXT};
    end
  end

  assign pc_stall     = stall_vec_s[9:8];
  assign if_id_stall  = stall_vec_s[7:6];
  assign id_ex_stall  = stall_vec_s[5:4];
  assign ex_mem_stall = stall_vec_s[3:2];
  assign mem_wb_stall = stall_vec_s[1:0];

  // Next-state logic of the fetch-discard FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        // A redirect while a fetch is still in flight leaves a stale word to drop.
        if (rule_redir_s & if_busy_s) begin
          state_d = S_FLUSH;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FLUSH: begin
        // The stale word lands this cycle and is zeroed in if_id.
        if (if_ready) begin
          state_d = S_RUN;
        end else begin
          state_d = S_FLUSH;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // Data-bus wait counter and stuck-access detection.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    timeout_d  = 1'b0;
    if (mem_busy_s) begin
      if (wait_cnt_q == WAIT_LAST) begin
        wait_cnt_d = 16'd0;
        timeout_d  = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 16'd1;
        timeout_d  = 1'b0;
      end
    end else begin
      wait_cnt_d = 16'd0;
      timeout_d  = 1'b0;
    end
  end

  // State registers for the FSM, wait counter and timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      wait_cnt_q <= 16'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign mem_timeout = timeout_q;
  assign flush_pend  = (state_q == S_FLUSH);

`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_lu_q;
  logic [CNT_W-1:0] cnt_fl_q;
  logic [CNT_W-1:0] cnt_mw_q;

  // Performance counters: one tick per cycle in which the matching rule wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_lu_q <= '0;
      cnt_fl_q <= '0;
      cnt_mw_q <= '0;
    end else begin
      if (rule_lu_s) begin
        cnt_lu_q <= cnt_lu_q + CNT_W'(1);
      end else begin
        cnt_lu_q <= cnt_lu_q;
      end
      if (rule_redir_s) begin
        cnt_fl_q <= cnt_fl_q + CNT_W'(1);
      end else begin
        cnt_fl_q <= cnt_fl_q;
      end
      if (rule_mem_s) begin
        cnt_mw_q <= cnt_mw_q + CNT_W'(1);
      end else begin
        cnt_mw_q <= cnt_mw_q;
      end
    end
  end

  assign cnt_load_use = cnt_lu_q;
  assign cnt_flush    = cnt_fl_q;
  assign cnt_mem_wait = cnt_mw_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl (MEM_TIMEOUT=4). A behavioural
// reference model is checked against the DUT on every falling edge, and
// directed vectors also carry hand-computed literal expectations.
module tb_pipe_stall_ctrl;

  localparam int MT = 4;

  // Patterns {pc, if_id, id_ex, ex_mem, mem_wb}.
  localparam logic [9:0] P_NEXT = 10'b00_00_00_00_00;
  localparam logic [9:0] P_MEM  = 10'b01_01_01_01_10;
  localparam logic [9:0] P_RED  = 10'b00_10_10_00_00;
  localparam logic [9:0] P_LU   = 10'b01_01_10_00_00;
  localparam logic [9:0] P_IF   = 10'b01_10_00_00_00;
  localparam logic [9:0] P_RST  = 10'b01_10_10_10_10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_waddr;
  logic       id_rs1_ren, id_rs2_ren, ex_mem_rena, ex_rd_wena, ex_redirect;
  logic       if_req, if_ready, mem_req, mem_ready;
  logic [1:0] pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
  logic       mem_timeout, flush_pend;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] cnt_load_use, cnt_flush, cnt_mem_wait;
`endif

  int total = 0;
  int bad = 0;

  // Reference model state.
  int  m_busy_run = 0;
  bit  m_to = 1'b0;
  bit  m_discard = 1'b0;
  int  m_lu = 0;
  int  m_fl = 0;
  int  m_mw = 0;

  pipe_stall_ctrl #(.MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren),
    .ex_mem_rena(ex_mem_rena), .ex_rd_wena(ex_rd_wena), .ex_rd_waddr(ex_rd_waddr),
    .ex_redirect(ex_redirect), .if_req(if_req), .if_ready(if_ready),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .mem_wb_stall(mem_wb_stall),
    .mem_timeout(mem_timeout), .flush_pend(flush_pend)
`ifdef STALL_PERF_CNT_EN
    , .cnt_load_use(cnt_load_use), .cnt_flush(cnt_flush), .cnt_mem_wait(cnt_mem_wait)
`endif
  );

  wire [9:0] stall_all = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall};

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model view of the hazard terms.
  function automatic bit f_mem_busy();
    return mem_req && !mem_ready;
  endfunction
  function automatic bit f_if_busy();
    return if_req && !if_ready;
  endfunction
  function automatic bit f_load_use();
    bit hit;
    hit = (id_rs1_ren && id_rs1_addr == ex_rd_waddr) || (id_rs2_ren && id_rs2_addr == ex_rd_waddr);
    return ex_mem_rena && ex_rd_wena && ex_rd_waddr != 5'd0 && hit;
  endfunction

  // Winning rule number: 0 reset, 1..5 hazards, 6 idle.
  function automatic int f_rule();
    if (!rst_n) return 0;
    if (f_mem_busy()) return 1;
    if (ex_redirect) return 2;
    if (f_load_use()) return 3;
    if (m_discard) return 4;
    if (f_if_busy()) return 5;
    return 6;
  endfunction

  function automatic logic [9:0] f_expect();
    logic [9:0] tbl [0:6];
    tbl[0] = P_RST; tbl[1] = P_MEM; tbl[2] = P_RED; tbl[3] = P_LU;
    tbl[4] = P_IF;  tbl[5] = P_IF;  tbl[6] = P_NEXT;
    return tbl[f_rule()];
  endfunction

  // Model update: run length of busy cycles, discard tracking, rule tallies.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy_run <= 0; m_to <= 1'b0; m_discard <= 1'b0;
      m_lu <= 0; m_fl <= 0; m_mw <= 0;
    end else begin
      m_busy_run <= f_mem_busy() ? m_busy_run + 1 : 0;
      m_to <= f_mem_busy() && ((m_busy_run + 1) % MT == 0);
      if (m_discard) m_discard <= !if_ready;
      else m_discard <= !f_mem_busy() && ex_redirect && f_if_busy();
      if (f_rule() == 1) m_mw <= m_mw + 1;
      if (f_rule() == 2) m_fl <= m_fl + 1;
      if (f_rule() == 3) m_lu <= m_lu + 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("model_stall", {22'd0, stall_all}, {22'd0, f_expect()});
    chk("model_timeout", {31'd0, mem_timeout}, {31'd0, m_to});
    chk("model_flush_pend", {31'd0, flush_pend}, {31'd0, m_discard});
`ifdef STALL_PERF_CNT_EN
    chk("model_cnt_lu", cnt_load_use, m_lu);
    chk("model_cnt_fl", cnt_flush, m_fl);
    chk("model_cnt_mw", cnt_mem_wait, m_mw);
`endif
  end

  task automatic idle_in();
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_waddr = 5'd0;
    id_rs1_ren = 1'b0; id_rs2_ren = 1'b0; ex_mem_rena = 1'b0; ex_rd_wena = 1'b0;
    ex_redirect = 1'b0; if_req = 1'b0; if_ready = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic lw_use(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic r1en, input logic r2en);
    ex_mem_rena = 1'b1; ex_rd_wena = 1'b1; ex_rd_waddr = rd;
    id_rs1_addr = rs1; id_rs2_addr = rs2; id_rs1_ren = r1en; id_rs2_ren = r2en;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_in();
    // Reset state.
    @(negedge clk);
    chk("rst_stall", {22'd0, stall_all}, {22'd0, P_RST});
    chk("rst_flush", {31'd0, flush_pend}, 32'd0);
    chk("rst_timeout", {31'd0, mem_timeout}, 32'd0);
    nxt(); rst_n = 1'b1;
    @(negedge clk);
    chk("idle_next", {22'd0, stall_all}, {22'd0, P_NEXT});

    // Load-use on rs1, then bubble.
    nxt(); lw_use(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    @(negedge clk); chk("lu_rs1", {22'd0, stall_all}, {22'd0, P_LU});
    nxt(); idle_in();
    @(negedge clk); chk("lu_after", {22'd0, stall_all}, {22'd0, P_NEXT});
    // rd = x0 never hazards.
    nxt(); lw_use(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    @(negedge clk); chk("lu_x0", {22'd0, stall_all}, {22'd0, P_NEXT});
    // rs2 match with ren, and without ren.
    nxt(); lw_use(5'd7, 5'd3, 5'd7, 1'b1, 1'b1);
    @(negedge clk); chk("lu_rs2", {22'd0, stall_all}, {22'd0, P_LU});
    nxt(); lw_use(5'd7, 5'd3, 5'd7, 1'b1, 1'b0);
    @(negedge clk); chk("lu_rs2_noren", {22'd0, stall_all}, {22'd0, P_NEXT});

    // Mem wait dominates load-use and redirect; redirect shows on ready.
    nxt(); lw_use(5'd9, 5'd9, 5'd0, 1'b1, 1'b0); ex_redirect = 1'b1; mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("mem_wait", {22'd0, stall_all}, {22'd0, P_MEM});
      nxt();
    end
    mem_ready = 1'b1;
    @(negedge clk); chk("mem_ready_redir", {22'd0, stall_all}, {22'd0, P_RED});
    nxt(); idle_in();

    // Redirect with a fetch in flight -> discard it.
    ex_redirect = 1'b1; if_req = 1'b1;
    @(negedge clk);
    chk("redir_if", {22'd0, stall_all}, {22'd0, P_RED});
    chk("redir_fp0", {31'd0, flush_pend}, 32'd0);
    nxt(); ex_redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("flush_wait", {22'd0, stall_all}, {22'd0, P_IF});
      chk("flush_fp1", {31'd0, flush_pend}, 32'd1);
      nxt();
    end
    if_ready = 1'b1;
    @(negedge clk);
    chk("flush_drop", {22'd0, stall_all}, {22'd0, P_IF});
    nxt(); idle_in();
    @(negedge clk);
    chk("flush_done", {31'd0, flush_pend}, 32'd0);
    chk("flush_done_st", {22'd0, stall_all}, {22'd0, P_NEXT});

    // Stuck data access: pulses on busy cycles 5 and 9.
    nxt(); mem_req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk("to_pulse", {31'd0, mem_timeout}, (i == 5 || i == 9) ? 32'd1 : 32'd0);
      chk("to_stall", {22'd0, stall_all}, {22'd0, P_MEM});
      nxt();
    end
    idle_in();
    @(negedge clk); chk("to_after", {31'd0, mem_timeout}, 32'd0);

    // Asynchronous reset during a pending flush.
    nxt(); ex_redirect = 1'b1; if_req = 1'b1;
    nxt(); ex_redirect = 1'b0;
    #1; chk("arst_pre", {31'd0, flush_pend}, 32'd1);
    #1; rst_n = 1'b0;
    #1;
    chk("arst_fp", {31'd0, flush_pend}, 32'd0);
    chk("arst_stall", {22'd0, stall_all}, {22'd0, P_RST});
    nxt(); rst_n = 1'b1; idle_in();
    @(negedge clk);
    chk("arst_rel", {22'd0, stall_all}, {22'd0, P_NEXT});

`ifdef STALL_PERF_CNT_EN
    // Two load-use cycles, one redirect, three mem-wait cycles.
    nxt(); lw_use(5'd4, 5'd4, 5'd0, 1'b1, 1'b0);
    nxt(); idle_in();
    nxt(); lw_use(5'd6, 5'd0, 5'd6, 1'b0, 1'b1);
    nxt(); idle_in(); ex_redirect = 1'b1;
    nxt(); idle_in(); mem_req = 1'b1;
    nxt(); nxt(); nxt(); idle_in();
    @(negedge clk);
    chk("perf_lu", cnt_load_use, 32'd2);
    chk("perf_fl", cnt_flush, 32'd1);
    chk("perf_mw", cnt_mem_wait, 32'd3);
`endif

    nxt();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
